// File: rtl/next_address_unit.sv
// Next-address sequencer feeding the program counter's d bus: increment, jump, branch, skip, hold, call/return.
// next_pc is combinational (zero cycles) from pc/op/cond/target/stack top; stack, sp and flags update on the next edge.
// Never stalls on its own: only op HOLD holds the PC; CALL on a full stack or RET on an empty one sets a sticky flag.
// Optional feature macro: NEXT_ADDR_CALL_STACK_EN (return stack, sp, ovf/unf). Undefined: CALL=JMP, RET=INC, sp/flags tied 0.
module next_address_unit #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   clr_n,
   input  logic [ADDR_W-1:0]      pc,
   input  logic [2:0]             op,
   input  logic                   cond,
   input  logic [ADDR_W-1:0]      target,
   output logic [ADDR_W-1:0]      next_pc,
   output logic [$clog2(DEPTH):0] sp,
   output logic                   stack_ovf,
   output logic                   stack_unf
);

   localparam int SP_W = $clog2(DEPTH) + 1;

   localparam logic [2:0] OP_INC  = 3'b000;
   localparam logic [2:0] OP_JMP  = 3'b001;
   localparam logic [2:0] OP_BR   = 3'b010;
   localparam logic [2:0] OP_CALL = 3'b011;
   localparam logic [2:0] OP_RET  = 3'b100;
   localparam logic [2:0] OP_HOLD = 3'b101;
   localparam logic [2:0] OP_SKIP = 3'b110;

   // Address arithmetic wraps at 2^ADDR_W by construction of the widths.
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] pc_inc2;

   assign pc_inc  = pc + ADDR_W'(1);
   assign pc_inc2 = pc + ADDR_W'(2);

`ifdef NEXT_ADDR_CALL_STACK_EN
   localparam int PTR_W = $clog2(DEPTH);

   logic [ADDR_W-1:0] stack_q [DEPTH];
   logic [ADDR_W-1:0] stack_d [DEPTH];
   logic [SP_W-1:0]   sp_q;
   logic [SP_W-1:0]   sp_d;
   logic              ovf_q;
   logic              ovf_d;
   logic              unf_q;
   logic              unf_d;

   logic              full;
   logic              empty;
   logic [PTR_W-1:0]  wr_idx;
   logic [PTR_W-1:0]  top_idx;
   logic [ADDR_W-1:0] top;

   // sp counts 0..DEPTH; its low bits wrap so sp==DEPTH still points the top at entry DEPTH-1.
   assign full    = (sp_q == SP_W'(DEPTH));
   assign empty   = (sp_q == '0);
   assign wr_idx  = sp_q[PTR_W-1:0];
   assign top_idx = wr_idx - PTR_W'(1);
   assign top     = stack_q[top_idx];

   // Next-address select plus push/pop and sticky-flag next state.
   always_comb begin
      next_pc = pc_inc;
      stack_d = stack_q;
      sp_d    = sp_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      case (op)
         OP_JMP:  next_pc = target;
         OP_BR:   next_pc = cond ? target : pc_inc;
         OP_CALL: begin
            // The jump is taken even when the push has to be dropped.
            next_pc = target;
            if (full) begin
               ovf_d = 1'b1;
            end else begin
               stack_d[wr_idx] = pc_inc;
               sp_d            = sp_q + SP_W'(1);
            end
         end
         OP_RET: begin
            // An empty stack falls through to pc+1 rather than returning garbage.
            if (empty) begin
               unf_d = 1'b1;
            end else begin
               next_pc = top;
               sp_d    = sp_q - SP_W'(1);
            end
         end
         OP_HOLD: next_pc = pc;
         OP_SKIP: next_pc = cond ? pc_inc2 : pc_inc;
         default: next_pc = pc_inc;
      endcase
      if (!clr_n) begin
         next_pc = '0;
      end
   end

   // Stack pointer and sticky flags; reset empties the stack logically.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         sp_q  <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         sp_q  <= sp_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // Stack storage is not cleared by reset; entries above sp are never read.
   always_ff @(posedge clk) begin
      stack_q <= stack_d;
   end

   assign sp        = sp_q;
   assign stack_ovf = ovf_q;
   assign stack_unf = unf_q;
`else
   logic unused_clk;
   assign unused_clk = clk;

   // Next-address select without a return stack: CALL jumps, RET increments.
   always_comb begin
      next_pc = pc_inc;
      case (op)
         OP_JMP:  next_pc = target;
         OP_BR:   next_pc = cond ? target : pc_inc;
         OP_CALL: next_pc = target;
         OP_RET:  next_pc = pc_inc;
         OP_HOLD: next_pc = pc;
         OP_SKIP: next_pc = cond ? pc_inc2 : pc_inc;
         default: next_pc = pc_inc;
      endcase
      if (!clr_n) begin
         next_pc = '0;
      end
   end

   assign sp        = '0;
   assign stack_ovf = 1'b0;
   assign stack_unf = 1'b0;
`endif

endmodule

// File: tb/tb_next_address_unit.sv
// Directed bench for next_address_unit with the bench itself acting as the PC.
// Checks next_pc mid-cycle after inputs settle, and sp/flags one edge later.
// Expectations follow whichever build (return stack on or off) is compiled.
module tb_next_address_unit;

   localparam int ADDR_W = 8;
   localparam int DEPTH  = 4;

`ifdef NEXT_ADDR_CALL_STACK_EN
   localparam bit EN = 1'b1;
`else
   localparam bit EN = 1'b0;
`endif

   localparam logic [2:0] OP_INC  = 3'b000;
   localparam logic [2:0] OP_JMP  = 3'b001;
   localparam logic [2:0] OP_BR   = 3'b010;
   localparam logic [2:0] OP_CALL = 3'b011;
   localparam logic [2:0] OP_RET  = 3'b100;
   localparam logic [2:0] OP_HOLD = 3'b101;
   localparam logic [2:0] OP_SKIP = 3'b110;
   localparam logic [2:0] OP_RSV  = 3'b111;

   logic                   clk = 1'b0;
   logic                   clr_n;
   logic [ADDR_W-1:0]      pc;
   logic [2:0]             op;
   logic                   cond;
   logic [ADDR_W-1:0]      target;
   logic [ADDR_W-1:0]      next_pc;
   logic [$clog2(DEPTH):0] sp;
   logic                   stack_ovf;
   logic                   stack_unf;

   int n_cmp = 0;
   int n_err = 0;

   next_address_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .clr_n     (clr_n),
      .pc        (pc),
      .op        (op),
      .cond      (cond),
      .target    (target),
      .next_pc   (next_pc),
      .sp        (sp),
      .stack_ovf (stack_ovf),
      .stack_unf (stack_unf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one op, check next_pc mid-cycle, then advance past the edge.
   task automatic step(input string tag, input logic [2:0] o, input logic [7:0] p,
                       input logic c, input logic [7:0] t, input logic [7:0] exp_npc);
      op = o; pc = p; cond = c; target = t;
      #2;
      chk(tag, {24'd0, next_pc}, {24'd0, exp_npc});
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string tag, input int exp_sp, input logic exp_ovf, input logic exp_unf);
      chk({tag, ".sp"},  {29'd0, sp}, EN ? exp_sp : 0);
      chk({tag, ".ovf"}, {31'd0, stack_ovf}, {31'd0, EN & exp_ovf});
      chk({tag, ".unf"}, {31'd0, stack_unf}, {31'd0, EN & exp_unf});
   endtask

   initial begin
      clr_n = 1'b0; op = OP_INC; pc = 8'h55; cond = 1'b0; target = 8'h00;
      #1;
      // Reset: next_pc forced to 0, state cleared after the edge.
      step("rst_npc", OP_CALL, 8'h55, 1'b1, 8'h77, 8'h00);
      chk_state("rst", 0, 1'b0, 1'b0);
      clr_n = 1'b1;

      // Increment loop from 0, then wrap at FF.
      step("inc0", OP_INC, 8'h00, 1'b0, 8'h00, 8'h01);
      step("inc1", OP_INC, 8'h01, 1'b0, 8'h00, 8'h02);
      step("inc2", OP_INC, 8'h02, 1'b0, 8'h00, 8'h03);
      chk_state("inc", 0, 1'b0, 1'b0);
      step("inc_wrap", OP_INC, 8'hFF, 1'b0, 8'h00, 8'h00);

      // Branch, skip, jump, hold, reserved.
      step("br_t",      OP_BR,   8'h10, 1'b1, 8'h40, 8'h40);
      step("br_nt",     OP_BR,   8'h10, 1'b0, 8'h40, 8'h11);
      step("skip_wrap", OP_SKIP, 8'hFE, 1'b1, 8'h40, 8'h00);
      step("skip_nt",   OP_SKIP, 8'h10, 1'b0, 8'h40, 8'h11);
      step("jmp",       OP_JMP,  8'h10, 1'b0, 8'h99, 8'h99);
      step("hold",      OP_HOLD, 8'h37, 1'b1, 8'h99, 8'h37);
      step("rsv",       OP_RSV,  8'h20, 1'b1, 8'h99, 8'h21);

      // Nested calls and returns; first RET follows its CALL directly.
      step("call1", OP_CALL, 8'h05, 1'b0, 8'h20, 8'h20);
      chk_state("call1", 1, 1'b0, 1'b0);
      step("call2", OP_CALL, 8'h20, 1'b0, 8'h30, 8'h30);
      chk_state("call2", 2, 1'b0, 1'b0);
      step("ret2", OP_RET, 8'h30, 1'b0, 8'h00, EN ? 8'h21 : 8'h31);
      chk_state("ret2", 1, 1'b0, 1'b0);
      step("ret1", OP_RET, 8'h21, 1'b0, 8'h00, EN ? 8'h06 : 8'h22);
      chk_state("ret1", 0, 1'b0, 1'b0);

      // Five calls into a four-deep stack.
      step("callA0", OP_CALL, 8'hA0, 1'b0, 8'hB0, 8'hB0);
      step("callA1", OP_CALL, 8'hA1, 1'b0, 8'hB1, 8'hB1);
      step("callA2", OP_CALL, 8'hA2, 1'b0, 8'hB2, 8'hB2);
      step("callA3", OP_CALL, 8'hA3, 1'b0, 8'hB3, 8'hB3);
      chk_state("full", 4, 1'b0, 1'b0);
      step("callA4", OP_CALL, 8'hA4, 1'b0, 8'hB4, 8'hB4);
      chk_state("ovf", 4, 1'b1, 1'b0);
      step("retA4", OP_RET, 8'hC0, 1'b0, 8'h00, EN ? 8'hA4 : 8'hC1);
      step("retA3", OP_RET, 8'hC0, 1'b0, 8'h00, EN ? 8'hA3 : 8'hC1);
      chk_state("pop2", 2, 1'b1, 1'b0);
      step("retA2", OP_RET, 8'hC0, 1'b0, 8'h00, EN ? 8'hA2 : 8'hC1);
      step("retA1", OP_RET, 8'hC0, 1'b0, 8'h00, EN ? 8'hA1 : 8'hC1);
      chk_state("pop4", 0, 1'b1, 1'b0);

      // Reset clears the overflow flag.
      clr_n = 1'b0;
      step("rst2_npc", OP_INC, 8'hC1, 1'b0, 8'h00, 8'h00);
      clr_n = 1'b1;
      chk_state("rst2", 0, 1'b0, 1'b0);

      // Underflow: falls through to pc+1, flag sticks.
      step("ret_unf", OP_RET, 8'h33, 1'b0, 8'h00, 8'h34);
      chk_state("unf", 0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         step("inc_loop", OP_INC, 8'h34 + 8'(i), 1'b0, 8'h00, 8'h35 + 8'(i));
      end
      chk_state("unf_sticky", 0, 1'b0, 1'b1);
      clr_n = 1'b0;
      step("rst3_npc", OP_INC, 8'h3E, 1'b0, 8'h00, 8'h00);
      clr_n = 1'b1;
      chk_state("rst3", 0, 1'b0, 1'b0);

      // Reset between CALL and RET discards pending returns.
      step("call07", OP_CALL, 8'h07, 1'b0, 8'h08, 8'h08);
      chk_state("sp1", 1, 1'b0, 1'b0);
      step("call08", OP_CALL, 8'h08, 1'b0, 8'h50, 8'h50);
      chk_state("sp2", 2, 1'b0, 1'b0);
      clr_n = 1'b0;
      step("rst4_npc", OP_RET, 8'h50, 1'b0, 8'h00, 8'h00);
      clr_n = 1'b1;
      chk_state("rst4", 0, 1'b0, 1'b0);
      step("ret_after_rst", OP_RET, 8'h00, 1'b0, 8'h00, 8'h01);
      chk_state("unf2", 0, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/next_address_unit.md
# next_address_unit

Next-address sequencer that sits on the input side of the program counter. Each cycle it takes the current address (`pc`, driven by the PC's `q`) and a control opcode, and produces `next_pc`, which drives the PC's `d` bus. Supported flows are increment, jump, conditional branch, conditional skip, hold, and call/return through an internal return-address stack. Sticky error flags report stack overflow and underflow.

## Interface
- `ADDR_W`, default 8: address width; must match the PC data bus.
- `DEPTH`, default 4: return-stack entries; must be a power of two, ≥2.
- `clk` in 1: clock; all state updates on the rising edge.
- `clr_n` in 1: synchronous, active-low reset.
- `pc` in ADDR_W: current program address from the program counter.
- `op` in 3: operation select for this cycle.
- `cond` in 1: condition flag from the ALU/status logic.
- `target` in ADDR_W: jump, branch or call destination.
- `next_pc` out ADDR_W: next address, to the PC `d` input.
- `sp` out $clog2(DEPTH)+1: return-stack occupancy, range 0..DEPTH.
- `stack_ovf` out 1: sticky flag; a CALL was issued while the stack was full.
- `stack_unf` out 1: sticky flag; a RET was issued while the stack was empty.

## Operation
- `next_pc` is combinational from `pc`, `op`, `cond`, `target` and the stack top. Stack, `sp` and flags are registered.
- All address arithmetic is modulo 2^ADDR_W: `pc+1` at 8'hFF gives 8'h00, and `pc+2` at 8'hFE gives 8'h00.
- Opcodes:
  - 000 INC: `next_pc = pc+1`.
  - 001 JMP: `next_pc = target`.
  - 010 BR: `next_pc = cond ? target : pc+1`.
  - 011 CALL: `next_pc = target`; push `pc+1`, then `sp+1`.
  - 100 RET: `next_pc = stack top`; pop, then `sp-1`.
  - 101 HOLD: `next_pc = pc` (stall).
  - 110 SKIP: `next_pc = cond ? pc+2 : pc+1`.
  - 111: reserved; behaves exactly as INC.
- CALL with `sp==DEPTH`: the jump to `target` is still taken, nothing is pushed, `sp` is unchanged, and `stack_ovf` is set.
- RET with `sp==0`: `next_pc = pc+1`, `sp` stays 0, and `stack_unf` is set.
- Flags stay set until reset; no other event clears them.
- Stack entries beyond `sp` are don't-care and are never driven onto `next_pc`.
- While `clr_n` is low:
  - `next_pc` = 0, regardless of `op`.
  - `sp` = 0, `stack_ovf` = 0, `stack_unf` = 0 after the edge.
  - Stack contents are invalidated; the entries are not cleared.
- Reset asserted mid-sequence (for example between a CALL and its RET) discards all pending returns. A following RET is then an underflow.

## Timing
- `next_pc` has zero-cycle latency from `pc`/`op`/`cond`/`target`. It is captured by the PC on the next rising edge, so the PC holds the new address one cycle after `op` is presented.
- Push/pop takes effect on the same edge that the PC loads `next_pc`. A RET in the cycle immediately after a CALL returns the address pushed by that CALL.
- `sp`, `stack_ovf` and `stack_unf` update on the same edge as the causing op and are visible in the following cycle.
- Reset values:
  - `next_pc` = 0 during reset (combinational override).
  - `sp` = 0.
  - `stack_ovf` = 0, `stack_unf` = 0.
- The first cycle after `clr_n` rises: `pc` is 0 (the PC was reset in parallel), and op INC gives `next_pc` = 1.
- No internal state machine other than the stack pointer. The block never stalls on its own; only op HOLD holds the PC.

## Configuration
- Macro: `NEXT_ADDR_CALL_STACK_EN`.
- Defined: return stack, `sp`, overflow/underflow logic and CALL/RET behave as described above.
- Undefined:
  - No stack storage is instantiated.
  - CALL behaves as JMP.
  - RET behaves as INC.
  - `sp`, `stack_ovf` and `stack_unf` are tied to 0.
  - All other opcodes are unchanged.

## Test plan
- Reset, then INC ×3 with the PC in loop: `next_pc` sequence 1, 2, 3; `sp`=0; flags 0. Apply `pc`=8'hFF with INC → `next_pc`=8'h00.
- `pc`=8'h10, BR, `target`=8'h40: with `cond`=1 → 8'h40; with `cond`=0 → 8'h11. SKIP at `pc`=8'hFE with `cond`=1 → 8'h00.
- Nested CALLs: at `pc`=8'h05 CALL 8'h20; at 8'h20 CALL 8'h30. `sp` goes to 2. RET → 8'h21, RET → 8'h06, `sp` back to 0, no flags.
- With DEPTH=4, five consecutive CALLs: `sp` saturates at 4 and `stack_ovf`=1 after the fifth. The fifth jump still goes to `target`. Four RETs return the first four return addresses in LIFO order.
- RET with `sp`=0 at `pc`=8'h33 → `next_pc`=8'h34 and `stack_unf`=1. The flag is still 1 after 10 INC cycles and clears only on `clr_n`=0.
- CALL at `pc`=8'h08 (`sp`=1), then `clr_n` low for one cycle: `next_pc`=0 during reset, and `sp`=0 and flags=0 after. A subsequent RET sets `stack_unf`.
